// File: rtl/mic_pkg.sv
// Shared sizing, types and helpers for the MIC read-return path.
// All MIC read-return modules import this package.
package mic_pkg;

    localparam int NREQS  = 4;
    localparam int MWIDTH = 32;
    localparam int RBITS  = $clog2(NREQS);
    localparam int MLAT   = 2;
    localparam int ODEPTH = 2;
    // Wide enough for a full FIFO plus a full tag pipe.
    localparam int CNTW   = $clog2(ODEPTH + MLAT + 1);

    typedef logic [RBITS-1:0]  req_id_t;
    typedef logic [MWIDTH-1:0] word_t;
    typedef logic [CNTW-1:0]   cnt_t;

    typedef struct packed {
        logic    vld;
        req_id_t id;
    } ret_tag_t;

    function automatic logic id_in_range(input req_id_t id);
        return {1'b0, id} < (RBITS + 1)'(NREQS);
    endfunction

endpackage

// File: rtl/mic_ret_fifo.sv
// Single-channel synchronous FIFO with a first-word-fall-through head.
// The head reads as zero while the FIFO is empty.
module mic_ret_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32,
    parameter int CNTW  = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNTW-1:0]  occ
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CNTW-1:0]  occ_q, occ_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_en;
    logic             pop_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (occ_q == CNTW'(DEPTH));
    assign empty = (occ_q == '0);
    assign occ   = occ_q;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        pop_en   = pop & ~empty;
        // A push into a full FIFO only lands when the head leaves in the same cycle.
        push_en  = push & (~full | pop_en);
        rd_ptr_d = pop_en  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = push_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        occ_d    = occ_q + CNTW'(push_en) - CNTW'(pop_en);
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // NOTE: storage is not reset; occupancy alone decides what is visible at the head.
    always_ff @(posedge clock) begin
        if (push_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/mic_read_return.sv
// Per-requester MIC read return: tag pipe, credit tracking and return FIFOs.
// Define MIC_RET_LASTREG_EN to add the per-channel last-read register output reg_out.
module mic_read_return
    import mic_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    issue_valid,
    input  logic [RBITS-1:0]        issue_id,
    output logic [NREQS-1:0]        issue_ready,
    input  logic [MWIDTH-1:0]       mem_rdata,
    output logic [NREQS-1:0]        rsp_valid,
    output logic [NREQS*MWIDTH-1:0] rsp_data,
    input  logic [NREQS-1:0]        rsp_ready,
    output logic                    err_overflow
`ifdef MIC_RET_LASTREG_EN
    ,
    output logic [NREQS*MWIDTH-1:0] reg_out
`endif
);

    ret_tag_t        tag_q [MLAT];
    ret_tag_t        tag_d [MLAT];
    ret_tag_t        last_tag;
    cnt_t            inflight_q [NREQS];
    cnt_t            inflight_d [NREQS];
    cnt_t            occ [NREQS];
    word_t           head [NREQS];
    logic [NREQS-1:0] full;
    logic [NREQS-1:0] empty;
    logic [NREQS-1:0] push;
    logic [NREQS-1:0] pop;
    logic            issue_ok;
    logic            err_q, err_d;

    assign last_tag     = tag_q[MLAT-1];
    assign err_overflow = err_q;

    always_comb begin
        tag_d[0].vld = issue_valid & id_in_range(issue_id);
        tag_d[0].id  = issue_id;
        for (int s = 1; s < MLAT; s++) begin
            tag_d[s] = tag_q[s-1];
        end
    end

    // Credits come from registered counters only, so a same-cycle pop cannot bypass.
    always_comb begin
        for (int i = 0; i < NREQS; i++) begin
            issue_ready[i] = ({1'b0, occ[i]} + {1'b0, inflight_q[i]}) < (CNTW + 1)'(ODEPTH);
            inflight_d[i]  = inflight_q[i]
                           + cnt_t'(tag_d[0].vld && (tag_d[0].id == RBITS'(i)))
                           - cnt_t'(last_tag.vld && (last_tag.id == RBITS'(i)));
            push[i]        = last_tag.vld && (last_tag.id == RBITS'(i)) && (~full[i] | pop[i]);
        end
        issue_ok = id_in_range(issue_id) && issue_ready[issue_id];
        err_d    = err_q | (issue_valid & ~issue_ok);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag_q      <= '{default: '0};
            inflight_q <= '{default: '0};
            err_q      <= 1'b0;
        end else begin
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    for (genvar g = 0; g < NREQS; g++) begin : g_chan
        mic_ret_fifo #(
            .DEPTH (ODEPTH),
            .WIDTH (MWIDTH),
            .CNTW  (CNTW)
        ) u_fifo (
            .clock     (clock),
            .reset_n   (reset_n),
            .push      (push[g]),
            .push_data (mem_rdata),
            .pop       (pop[g]),
            .head      (head[g]),
            .full      (full[g]),
            .empty     (empty[g]),
            .occ       (occ[g])
        );

        assign rsp_valid[g]                   = ~empty[g];
        assign pop[g]                         = ~empty[g] & rsp_ready[g];
        assign rsp_data[g*MWIDTH +: MWIDTH]   = head[g];
    end

`ifdef MIC_RET_LASTREG_EN
    word_t reg_out_q [NREQS];
    word_t reg_out_d [NREQS];

    always_comb begin
        for (int i = 0; i < NREQS; i++) begin
            reg_out_d[i] = pop[i] ? head[i] : reg_out_q[i];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reg_out_q <= '{default: '0};
        end else begin
            reg_out_q <= reg_out_d;
        end
    end

    for (genvar g = 0; g < NREQS; g++) begin : g_lastreg
        assign reg_out[g*MWIDTH +: MWIDTH] = reg_out_q[g];
    end
`endif

endmodule

// File: tb/tb_mic_read_return.sv
// Self-checking bench for mic_read_return: directed scenarios plus randomized traffic
// compared every cycle against a timestamp/queue reference model.
module tb_mic_read_return;
    import mic_pkg::*;

    typedef logic [NREQS*MWIDTH-1:0] wide_t;

    typedef struct {
        int cyc;
        int id;
    } pend_t;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              issue_valid = 1'b0;
    logic [RBITS-1:0]  issue_id = '0;
    logic [NREQS-1:0]  issue_ready;
    logic [MWIDTH-1:0] mem_rdata = '0;
    logic [NREQS-1:0]  rsp_valid;
    wide_t             rsp_data;
    logic [NREQS-1:0]  rsp_ready = '0;
    logic              err_overflow;
`ifdef MIC_RET_LASTREG_EN
    wide_t             reg_out;
`endif

    mic_read_return dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .issue_valid  (issue_valid),
        .issue_id     (issue_id),
        .issue_ready  (issue_ready),
        .mem_rdata    (mem_rdata),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_ready    (rsp_ready),
        .err_overflow (err_overflow)
`ifdef MIC_RET_LASTREG_EN
        ,
        .reg_out      (reg_out)
`endif
    );

    always #5 clock = ~clock;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    word_t mq [NREQS][$];
    pend_t pq [$];
    bit    err_m = 1'b0;
    word_t last_m [NREQS];

    task automatic check(input string tag, input wide_t got, input wide_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit exp_ready(input int ch);
        int n = mq[ch].size();
        foreach (pq[k]) if (pq[k].id == ch) n++;
        return n < ODEPTH;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NREQS; i++) begin
            mq[i].delete();
            last_m[i] = '0;
        end
        pq.delete();
        err_m = 1'b0;
    endfunction

    function automatic void model_update(input logic iv, input int id, input logic [NREQS-1:0] rdy,
                                         input word_t rd);
        bit    popping [NREQS];
        pend_t e;
        bit    do_push = 1'b0;
        int    push_ch = 0;
        if (iv && (id >= NREQS || !exp_ready(id))) err_m = 1'b1;
        for (int i = 0; i < NREQS; i++) popping[i] = (mq[i].size() > 0) && rdy[i];
        if (pq.size() > 0 && pq[0].cyc == cyc - MLAT) begin
            e = pq.pop_front();
            if (mq[e.id].size() < ODEPTH || popping[e.id]) begin
                do_push = 1'b1;
                push_ch = e.id;
            end
        end
        for (int i = 0; i < NREQS; i++) begin
            if (popping[i]) last_m[i] = mq[i].pop_front();
        end
        if (do_push) mq[push_ch].push_back(rd);
        if (iv && id < NREQS) begin
            e.cyc = cyc;
            e.id  = id;
            pq.push_back(e);
        end
    endfunction

    task automatic check_outputs();
        logic [NREQS-1:0] ev;
        logic [NREQS-1:0] er;
        wide_t            ed;
        wide_t            el;
        ev = '0;
        er = '0;
        ed = '0;
        el = '0;
        for (int i = 0; i < NREQS; i++) begin
            ev[i] = mq[i].size() > 0;
            er[i] = exp_ready(i);
            if (ev[i]) ed[i*MWIDTH +: MWIDTH] = mq[i][0];
            el[i*MWIDTH +: MWIDTH] = last_m[i];
        end
        check("rsp_valid", wide_t'(rsp_valid), wide_t'(ev));
        check("rsp_data", rsp_data, ed);
        check("issue_ready", wide_t'(issue_ready), wide_t'(er));
        check("err_overflow", wide_t'(err_overflow), wide_t'(err_m));
`ifdef MIC_RET_LASTREG_EN
        check("reg_out", reg_out, el);
`endif
    endtask

    // One clock cycle: check state at the falling edge, drive inputs, advance the model.
    task automatic step(input logic iv, input int id, input logic [NREQS-1:0] rdy, input word_t rd);
        @(negedge clock);
        check_outputs();
        issue_valid = iv;
        issue_id    = RBITS'(id);
        rsp_ready   = rdy;
        mem_rdata   = rd;
        @(posedge clock);
        model_update(iv, id, rdy, rd);
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clock);
        issue_valid = 1'b0;
        rsp_ready   = '0;
        reset_n     = 1'b0;
        model_clear();
        #1;
        check_outputs();
        @(posedge clock);
        cyc++;
        #2 reset_n = 1'b1;
    endtask

    task automatic drain();
        repeat (MLAT + ODEPTH + 2) step(1'b0, 0, '1, $urandom);
    endtask

    initial begin
        model_clear();
        #1;
        check_outputs();
        @(posedge clock);
        #2 reset_n = 1'b1;

        // Single read on channel 1.
        step(1'b1, 1, '0, $urandom);
        step(1'b0, 0, '0, $urandom);
        step(1'b0, 0, '0, 32'hCAFE_0001);
        #2;
        check("t1_valid", wide_t'(rsp_valid), wide_t'(4'b0010));
        check("t1_data", wide_t'(rsp_data[1*MWIDTH +: MWIDTH]), wide_t'(32'hCAFE_0001));
        step(1'b0, 0, 4'b0010, $urandom);
        drain();

        // Two back-to-back reads on channel 0, held, then one pop.
        step(1'b1, 0, '0, $urandom);
        step(1'b1, 0, '0, $urandom);
        #2;
        check("t2_ready0_low", wide_t'(issue_ready[0]), wide_t'(1'b0));
        step(1'b0, 0, '0, 32'h0000_00A0);
        step(1'b0, 0, '0, 32'h0000_00A1);
        step(1'b0, 0, '0, $urandom);
        step(1'b0, 0, 4'b0001, $urandom);
        #2;
        check("t2_ready0_back", wide_t'(issue_ready[0]), wide_t'(1'b1));
        check("t2_second_word", wide_t'(rsp_data[MWIDTH-1:0]), wide_t'(32'h0000_00A1));
        drain();

        // Interleaved ids with consecutive data.
        step(1'b1, 3, '0, $urandom);
        step(1'b1, 2, '0, $urandom);
        step(1'b1, 3, '0, 32'd10);
        step(1'b1, 0, '0, 32'd11);
        step(1'b0, 0, '0, 32'd12);
        step(1'b0, 0, '0, 32'd13);
        step(1'b0, 0, '0, $urandom);
        step(1'b0, 0, 4'b1000, $urandom);
        step(1'b0, 0, 4'b1000, $urandom);
        drain();

        // Overflow on a full channel 2 without a pop.
        step(1'b1, 2, '0, $urandom);
        step(1'b1, 2, '0, $urandom);
        step(1'b0, 0, '0, 32'h0000_0201);
        step(1'b0, 0, '0, 32'h0000_0202);
        step(1'b1, 2, '0, $urandom);
        step(1'b0, 0, '0, $urandom);
        step(1'b0, 0, '0, 32'hDEAD_BEEF);
        step(1'b0, 0, '0, $urandom);
        #2;
        check("t4_err", wide_t'(err_overflow), wide_t'(1'b1));
        check("t4_head", wide_t'(rsp_data[2*MWIDTH +: MWIDTH]), wide_t'(32'h0000_0201));
        drain();
        #2;
        check("t4_err_sticky", wide_t'(err_overflow), wide_t'(1'b1));

        // Reset with a read in flight.
        step(1'b1, 1, '0, $urandom);
        do_reset();
        step(1'b0, 0, '0, 32'h1234_5678);
        step(1'b0, 0, '0, $urandom);
        #2;
        check("t5_valid", wide_t'(rsp_valid), wide_t'(4'b0000));
        check("t5_ready", wide_t'(issue_ready), wide_t'(4'b1111));
        check("t5_err", wide_t'(err_overflow), wide_t'(1'b0));

`ifdef MIC_RET_LASTREG_EN
        step(1'b1, 0, '0, $urandom);
        step(1'b0, 0, '0, $urandom);
        step(1'b0, 0, '0, 32'h55);
        step(1'b0, 0, 4'b0001, $urandom);
        #2;
        check("t6_reg55", wide_t'(reg_out[MWIDTH-1:0]), wide_t'(32'h55));
        step(1'b1, 0, '0, $urandom);
        step(1'b0, 0, '0, $urandom);
        step(1'b0, 0, '0, 32'hAA);
        step(1'b0, 0, 4'b0001, $urandom);
        repeat (3) step(1'b0, 0, '0, $urandom);
        #2;
        check("t6_regAA", wide_t'(reg_out[MWIDTH-1:0]), wide_t'(32'hAA));
`endif

        // Randomized traffic; issues mostly honour credits, occasionally violate them.
        for (int n = 0; n < 1500; n++) begin
            logic iv;
            int   id;
            if (n % 250 == 249) do_reset();
            id = $urandom_range(0, NREQS - 1);
            iv = ($urandom_range(0, 9) < 6);
            if (iv && !exp_ready(id) && $urandom_range(0, 19) != 0) iv = 1'b0;
            step(iv, id, NREQS'($urandom), $urandom);
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
